// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and constants for the ROM loader.
//   wr_entry_t    : one buffered SDRAM word write {a, ds, d}
//   issue_state_t : SDRAM write issue FSM states
//   DS_*          : byte-enable encodings {hi, lo}
package rom_loader_pkg;

   typedef struct packed {
      logic [22:0] a;
      logic [1:0]  ds;
      logic [15:0] d;
   } wr_entry_t;

   typedef enum logic {
      IDLE,
      WAIT
   } issue_state_t;

   localparam logic [1:0] DS_LO   = 2'b01;
   localparam logic [1:0] DS_HI   = 2'b10;
   localparam logic [1:0] DS_BOTH = 2'b11;

endpackage

// File: rtl/rom_loader_fifo.sv
// rom_loader_fifo: synchronous FIFO of word-write entries.
// Ports:
//   clk_sys, reset_n    : clock, asynchronous active-low reset (flushes FIFO)
//   push, push_data     : write side; a push while full is dropped
//   pop, pop_data       : read side; pop_data shows the head entry (first-word fall-through)
//   full, empty         : occupancy flags
//   overflow            : sticky, a push was dropped
module rom_loader_fifo
   import rom_loader_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic      clk_sys,
   input  logic      reset_n,
   input  logic      push,
   input  wr_entry_t push_data,
   input  logic      pop,
   output wr_entry_t pop_data,
   output logic      full,
   output logic      empty,
   output logic      overflow
);

   localparam int AW = $clog2(DEPTH);

   wr_entry_t   mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // NOTE: the storage array has no reset; only the pointers define which entries are valid,
   // and leaving the array unreset lets it map onto plain RAM/flop arrays without reset muxes.
   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // NOTE: sequential state is assigned with non-blocking (<=) so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !do_push) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: packs the data_io byte stream into 16-bit SDRAM word writes, buffers them,
// issues them over the toggle req/ack port, and holds the core in reset until the ROM is loaded.
// Optional: define ROM_LOADER_CSUM_EN to add rom_csum (16-bit wrapping sum of accepted bytes).
// Ports:
//   clk_sys, reset_n            : clock, asynchronous active-low reset
//   ioctl_download/index/wr/addr/dout : data_io download interface (byte stream)
//   soft_reset                  : restarts the reset hold counter
//   port_req/ack/a/ds/d/we      : SDRAM write port, toggle handshake
//   rom_loaded                  : sticky, all words of the download are acked
//   reset_out                   : active-high core reset
//   overflow                    : sticky, a word was dropped because the FIFO was full
//   rom_csum (optional)         : byte checksum of the download
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int         FIFO_DEPTH = 8,
   parameter int         RESET_HOLD = 65535,
   parameter logic [7:0] ROM_INDEX  = 8'd0
)(
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        soft_reset,
   output logic        port_req,
   input  logic        port_ack,
   output logic [22:0] port_a,
   output logic [1:0]  port_ds,
   output logic [15:0] port_d,
   output logic        port_we,
   output logic        rom_loaded,
   output logic        reset_out,
   output logic        overflow
`ifdef ROM_LOADER_CSUM_EN
   ,
   output logic [15:0] rom_csum
`endif
);

   localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);

   // ---------------- byte capture ----------------
   logic        wr_d, dl_d, dl_seen;
   logic        idx_ok, capture, dl_start, dl_fall;
   logic [22:0] byte_a;

   assign idx_ok   = (ioctl_index == ROM_INDEX);
   assign capture  = ioctl_wr && !wr_d && ioctl_download && idx_ok;
   assign dl_start = ioctl_download && !dl_d && idx_ok;
   assign dl_fall  = dl_d && !ioctl_download;
   assign byte_a   = ioctl_addr[23:1];

   // ---------------- packing ----------------
   logic        pend_v, carry_v;
   logic [22:0] pend_a;
   logic [7:0]  pend_d;
   wr_entry_t   carry_e, pend_entry, hi_entry, push_e;
   logic        push, pend_load, pend_clear, carry_load;

   assign pend_entry = '{a: pend_a, ds: DS_LO, d: {8'h00, pend_d}};
   assign hi_entry   = '{a: byte_a, ds: DS_HI, d: {ioctl_dout, 8'h00}};

   // Captures are at least two cycles apart (the strobe must drop in between), so the
   // carried second push of an odd byte never collides with the next capture.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned
   // (which would infer a latch).
   always_comb begin
      push       = 1'b0;
      push_e     = pend_entry;
      pend_load  = 1'b0;
      pend_clear = 1'b0;
      carry_load = 1'b0;
      if (carry_v) begin
         push   = 1'b1;
         push_e = carry_e;
      end else if (capture) begin
         if (!ioctl_addr[0]) begin
            push      = pend_v;
            pend_load = 1'b1;
         end else if (pend_v && pend_a == byte_a) begin
            push       = 1'b1;
            push_e     = '{a: byte_a, ds: DS_BOTH, d: {ioctl_dout, pend_d}};
            pend_clear = 1'b1;
         end else if (pend_v) begin
            push       = 1'b1;
            pend_clear = 1'b1;
            carry_load = 1'b1;
         end else begin
            push   = 1'b1;
            push_e = hi_entry;
         end
      end else if (dl_fall && pend_v) begin
         push       = 1'b1;
         pend_clear = 1'b1;
      end
   end

   // ---------------- FIFO ----------------
   wr_entry_t head;
   logic      fifo_full, fifo_empty, pop;

   rom_loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_e),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .overflow  (overflow)
   );

   // ---------------- issue FSM ----------------
   issue_state_t state, state_nxt;
   logic         busy, retire, load_done;

   assign busy = (port_req != port_ack);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      retire    = 1'b0;
      case (state)
         IDLE: if (!fifo_empty && !busy) begin
            pop       = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: if (!busy) begin
            retire    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign load_done = !ioctl_download && dl_seen && fifo_empty && !pend_v && !carry_v &&
                      (state == IDLE) && !busy;

   // ---------------- reset generator ----------------
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;

   always_comb begin
      hold_nxt = hold_cnt;
      if (!rom_loaded || soft_reset) hold_nxt = HOLD_INIT;
      else if (hold_cnt != '0)       hold_nxt = hold_cnt - 1'b1;
   end

   // reset_out registers the next count so a soft reset raises it on the very next edge.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_d       <= 1'b0;
         dl_d       <= 1'b0;
         dl_seen    <= 1'b0;
         pend_v     <= 1'b0;
         pend_a     <= '0;
         pend_d     <= '0;
         carry_v    <= 1'b0;
         carry_e    <= '0;
         rom_loaded <= 1'b0;
         hold_cnt   <= HOLD_INIT;
         reset_out  <= 1'b1;
         state      <= IDLE;
         port_req   <= 1'b0;
         port_we    <= 1'b0;
         port_a     <= '0;
         port_ds    <= '0;
         port_d     <= '0;
      end else begin
         wr_d      <= ioctl_wr;
         dl_d      <= ioctl_download;
         hold_cnt  <= hold_nxt;
         reset_out <= (hold_nxt != '0);
         state     <= state_nxt;
         if (dl_start) dl_seen <= 1'b1;
         if (pend_load) begin
            pend_v <= 1'b1;
            pend_a <= byte_a;
            pend_d <= ioctl_dout;
         end else if (pend_clear) begin
            pend_v <= 1'b0;
         end
         carry_v <= carry_load;
         if (carry_load) carry_e <= hi_entry;
         if (dl_start)       rom_loaded <= 1'b0;
         else if (load_done) rom_loaded <= 1'b1;
         if (pop) begin
            port_a   <= head.a;
            port_ds  <= head.ds;
            port_d   <= head.d;
            port_we  <= 1'b1;
            port_req <= ~port_req;
         end else if (retire) begin
            port_we <= 1'b0;
         end
      end
   end

`ifdef ROM_LOADER_CSUM_EN
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)      rom_csum <= '0;
      else if (dl_start) rom_csum <= capture ? {8'h00, ioctl_dout} : 16'h0000;
      else if (capture)  rom_csum <= rom_csum + {8'h00, ioctl_dout};
   end
`endif

   // Address bit 24 is beyond the SDRAM word range; FIFO full is not needed here.
   logic unused_bits;
   assign unused_bits = ^{ioctl_addr[24], fifo_full};

endmodule
